// File: rtl/orb_serializer.sv
// Read-side stage of the orbital word buffer: fetches one RAM word per frame
// request, shifts it out MSB-first and flips the buffer half select on wrap.
module orb_serializer #(
    parameter int WORD_W    = 12,
    parameter int ADDR_W    = 11,
    parameter int ADDR_STEP = 2,
    parameter int LAST_ADDR = 2046,
    parameter int BIT_DIV   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [WORD_W-1:0] RdData,
    output logic [ADDR_W-1:0] RdAddr,
    output logic              sOut,
    output logic              bitStrob,
    output logic              done,
    output logic              SW,
    output logic              overrun
);

    localparam int BCNT_W = $clog2(WORD_W);
    localparam int DIV_W  = $clog2(BIT_DIV);

    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(WORD_W - 1);
    localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(BIT_DIV - 1);
    localparam logic [ADDR_W-1:0] WRAP_ADDR = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, NEXT} state_t;

    state_t              state, state_nxt;
    logic [1:0]          req_sync;
    logic                req_dly;
    logic                req_edge;
    logic                fetch_cnt, fetch_cnt_nxt;
    logic [BCNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [DIV_W-1:0]    div_cnt, div_cnt_nxt;
    // sOut carries the current MSB, so the shifter only keeps the bits below it.
    logic [WORD_W-2:0]   shreg, shreg_nxt;
    logic [ADDR_W-1:0]   rd_addr_nxt;
    logic                sout_nxt, strobe_nxt, done_nxt, sw_nxt, overrun_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_sync <= '0;
            req_dly  <= 1'b0;
        end else begin
            req_sync <= {req_sync[0], req};
            req_dly  <= req_sync[1];
        end
    end

    assign req_edge = req_sync[1] & ~req_dly;

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // independent of statement order inside the block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_cnt <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            shreg     <= '0;
            RdAddr    <= '0;
            sOut      <= 1'b0;
            bitStrob  <= 1'b0;
            done      <= 1'b0;
            SW        <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            fetch_cnt <= fetch_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            div_cnt   <= div_cnt_nxt;
            shreg     <= shreg_nxt;
            RdAddr    <= rd_addr_nxt;
            sOut      <= sout_nxt;
            bitStrob  <= strobe_nxt;
            done      <= done_nxt;
            SW        <= sw_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // NOTE: every signal gets its hold value before the case so no path
    // through the block leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt     = state;
        fetch_cnt_nxt = fetch_cnt;
        bit_cnt_nxt   = bit_cnt;
        div_cnt_nxt   = div_cnt;
        shreg_nxt     = shreg;
        rd_addr_nxt   = RdAddr;
        sout_nxt      = sOut;
        strobe_nxt    = 1'b0;
        done_nxt      = 1'b0;
        sw_nxt        = SW;
        overrun_nxt   = overrun | (req_edge && state != IDLE);

        unique case (state)
            IDLE: begin
                sout_nxt = 1'b0;
                if (req_edge) begin
                    state_nxt     = FETCH;
                    fetch_cnt_nxt = 1'b0;
                end
            end
            FETCH: begin
                if (fetch_cnt) begin
                    shreg_nxt   = RdData[WORD_W-2:0];
                    sout_nxt    = RdData[WORD_W-1];
                    strobe_nxt  = 1'b1;
                    bit_cnt_nxt = '0;
                    div_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end else begin
                    fetch_cnt_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt != LAST_DIV) begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end else if (bit_cnt == LAST_BIT) begin
                    // Address advance and half-select flip land with done.
                    state_nxt = NEXT;
                    done_nxt  = 1'b1;
                    sout_nxt  = 1'b0;
                    if (RdAddr == WRAP_ADDR) begin
                        rd_addr_nxt = '0;
                        sw_nxt      = ~SW;
                    end else begin
                        rd_addr_nxt = RdAddr + STEP;
                    end
                end else begin
                    sout_nxt    = shreg[WORD_W-2];
                    shreg_nxt   = {shreg[WORD_W-3:0], 1'b0};
                    strobe_nxt  = 1'b1;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    div_cnt_nxt = '0;
                end
            end
            NEXT: begin
                sout_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
